// File: rtl/cabac_decode_bin_core.sv
// rtl/cabac_decode_bin_core.sv - single-bin CABAC context-coded decision decoder
//
// Purpose: decodes one context-coded bin from the arithmetic-decoder state and a
// context model. Also produces the updated context, the renormalised range/offset
// and the number of bitstream bits consumed. Purely combinational; the caller
// registers every result on its own clock edge.
//
// Ports:
//   clk, rst        clock / sync active-low reset (no effect: no internal state)
//   i_ivlCurrRange  [8:0] current range, 256..510
//   i_ivlOffset     [8:0] current offset, < i_ivlCurrRange
//   i_pStateIdx     [5:0] context probability state, 0..62 (63 reserved)
//   i_valMps        MPS value of the context
//   i_rbsp_in       [5:0] next unread bitstream bits, [5] read first
//   o_ivlCurrRange  [8:0] renormalised range
//   o_ivlOffset     [8:0] renormalised offset
//   o_pStateIdx     [5:0] updated state
//   o_valMps        updated MPS
//   o_binVal        decoded bin
//   o_output_len    [2:0] bits consumed by renormalisation, 0..6
module cabac_decode_bin_core (
   input  logic       clk,
   input  logic       rst,
   input  logic [8:0] i_ivlCurrRange,
   input  logic [8:0] i_ivlOffset,
   input  logic [5:0] i_pStateIdx,
   input  logic       i_valMps,
   input  logic [5:0] i_rbsp_in,
   output logic [8:0] o_ivlCurrRange,
   output logic [8:0] o_ivlOffset,
   output logic [5:0] o_pStateIdx,
   output logic       o_valMps,
   output logic       o_binVal,
   output logic [2:0] o_output_len
);

   // clk/rst exist only for interface uniformity with the slice-data engine.
   logic unused_ok;
   assign unused_ok = &{1'b0, clk, rst};

   // rangeTabLps row for one state, packed {q0, q1, q2, q3}.
   function automatic logic [31:0] lps_row(input logic [5:0] p);
      logic [31:0] r;
      case (p)
         6'd0:  r = {8'd128, 8'd176, 8'd208, 8'd240};  6'd1:  r = {8'd128, 8'd167, 8'd197, 8'd227};
         6'd2:  r = {8'd128, 8'd158, 8'd187, 8'd216};  6'd3:  r = {8'd123, 8'd150, 8'd178, 8'd205};
         6'd4:  r = {8'd116, 8'd142, 8'd169, 8'd195};  6'd5:  r = {8'd111, 8'd135, 8'd160, 8'd185};
         6'd6:  r = {8'd105, 8'd128, 8'd152, 8'd175};  6'd7:  r = {8'd100, 8'd122, 8'd144, 8'd166};
         6'd8:  r = {8'd95,  8'd116, 8'd137, 8'd158};  6'd9:  r = {8'd90,  8'd110, 8'd130, 8'd150};
         6'd10: r = {8'd85,  8'd104, 8'd123, 8'd142};  6'd11: r = {8'd81,  8'd99,  8'd117, 8'd135};
         6'd12: r = {8'd77,  8'd94,  8'd111, 8'd128};  6'd13: r = {8'd73,  8'd89,  8'd105, 8'd122};
         6'd14: r = {8'd69,  8'd85,  8'd100, 8'd116};  6'd15: r = {8'd66,  8'd80,  8'd95,  8'd110};
         6'd16: r = {8'd62,  8'd76,  8'd90,  8'd104};  6'd17: r = {8'd59,  8'd72,  8'd86,  8'd99};
         6'd18: r = {8'd56,  8'd69,  8'd81,  8'd94};   6'd19: r = {8'd53,  8'd65,  8'd77,  8'd89};
         6'd20: r = {8'd51,  8'd62,  8'd73,  8'd85};   6'd21: r = {8'd48,  8'd59,  8'd69,  8'd80};
         6'd22: r = {8'd46,  8'd56,  8'd66,  8'd76};   6'd23: r = {8'd43,  8'd53,  8'd63,  8'd72};
         6'd24: r = {8'd41,  8'd50,  8'd59,  8'd69};   6'd25: r = {8'd39,  8'd48,  8'd56,  8'd65};
         6'd26: r = {8'd37,  8'd45,  8'd54,  8'd62};   6'd27: r = {8'd35,  8'd43,  8'd51,  8'd59};
         6'd28: r = {8'd33,  8'd41,  8'd48,  8'd56};   6'd29: r = {8'd32,  8'd39,  8'd46,  8'd53};
         6'd30: r = {8'd30,  8'd37,  8'd43,  8'd50};   6'd31: r = {8'd29,  8'd35,  8'd41,  8'd48};
         6'd32: r = {8'd27,  8'd33,  8'd39,  8'd45};   6'd33: r = {8'd26,  8'd31,  8'd37,  8'd43};
         6'd34: r = {8'd24,  8'd30,  8'd35,  8'd41};   6'd35: r = {8'd23,  8'd28,  8'd33,  8'd39};
         6'd36: r = {8'd22,  8'd27,  8'd32,  8'd37};   6'd37: r = {8'd21,  8'd26,  8'd30,  8'd35};
         6'd38: r = {8'd20,  8'd24,  8'd29,  8'd33};   6'd39: r = {8'd19,  8'd23,  8'd27,  8'd31};
         6'd40: r = {8'd18,  8'd22,  8'd26,  8'd30};   6'd41: r = {8'd17,  8'd21,  8'd25,  8'd28};
         6'd42: r = {8'd16,  8'd20,  8'd23,  8'd27};   6'd43: r = {8'd15,  8'd19,  8'd22,  8'd25};
         6'd44: r = {8'd14,  8'd18,  8'd21,  8'd24};   6'd45: r = {8'd14,  8'd17,  8'd20,  8'd23};
         6'd46: r = {8'd13,  8'd16,  8'd19,  8'd22};   6'd47: r = {8'd12,  8'd15,  8'd18,  8'd21};
         6'd48: r = {8'd12,  8'd14,  8'd17,  8'd20};   6'd49: r = {8'd11,  8'd14,  8'd16,  8'd19};
         6'd50: r = {8'd11,  8'd13,  8'd15,  8'd18};   6'd51: r = {8'd10,  8'd12,  8'd15,  8'd17};
         6'd52: r = {8'd10,  8'd12,  8'd14,  8'd16};   6'd53: r = {8'd9,   8'd11,  8'd13,  8'd15};
         6'd54: r = {8'd9,   8'd11,  8'd12,  8'd14};   6'd55: r = {8'd8,   8'd10,  8'd12,  8'd14};
         6'd56: r = {8'd8,   8'd9,   8'd11,  8'd13};   6'd57: r = {8'd7,   8'd9,   8'd11,  8'd12};
         6'd58: r = {8'd7,   8'd9,   8'd10,  8'd12};   6'd59: r = {8'd7,   8'd8,   8'd10,  8'd11};
         6'd60: r = {8'd6,   8'd8,   8'd9,   8'd11};   6'd61: r = {8'd6,   8'd7,   8'd9,   8'd10};
         6'd62: r = {8'd6,   8'd7,   8'd8,   8'd9};
         default: r = {8'd2, 8'd2, 8'd2, 8'd2};
      endcase
      return r;
   endfunction

   // transIdxLps, grouped by result value.
   function automatic logic [5:0] trans_lps(input logic [5:0] p);
      logic [5:0] r;
      case (p)
         6'd0, 6'd1:          r = 6'd0;   6'd2:                r = 6'd1;
         6'd3, 6'd4:          r = 6'd2;   6'd5, 6'd6:          r = 6'd4;
         6'd7:                r = 6'd5;   6'd8:                r = 6'd6;
         6'd9:                r = 6'd7;   6'd10:               r = 6'd8;
         6'd11, 6'd12:        r = 6'd9;   6'd13, 6'd14:        r = 6'd11;
         6'd15:               r = 6'd12;  6'd16, 6'd17:        r = 6'd13;
         6'd18, 6'd19:        r = 6'd15;  6'd20, 6'd21:        r = 6'd16;
         6'd22, 6'd23:        r = 6'd18;  6'd24, 6'd25:        r = 6'd19;
         6'd26, 6'd27:        r = 6'd21;  6'd28, 6'd29:        r = 6'd22;
         6'd30:               r = 6'd23;  6'd31, 6'd32:        r = 6'd24;
         6'd33:               r = 6'd25;  6'd34, 6'd35:        r = 6'd26;
         6'd36, 6'd37:        r = 6'd27;  6'd38:               r = 6'd28;
         6'd39, 6'd40:        r = 6'd29;  6'd41, 6'd42, 6'd43: r = 6'd30;
         6'd44:               r = 6'd31;  6'd45, 6'd46:        r = 6'd32;
         6'd47, 6'd48, 6'd49: r = 6'd33;  6'd50, 6'd51:        r = 6'd34;
         6'd52, 6'd53, 6'd54: r = 6'd35;  6'd55, 6'd56, 6'd57: r = 6'd36;
         6'd58, 6'd59, 6'd60: r = 6'd37;  6'd61, 6'd62:        r = 6'd38;
         default:             r = 6'd63;
      endcase
      return r;
   endfunction

   logic [31:0] row;
   logic [7:0]  lps;
   logic [8:0]  r_mps;
   logic        is_lps;
   logic [8:0]  range_pre;
   logic [8:0]  offset_pre;
   logic [2:0]  len;
   logic [14:0] off_ext;

   always_comb begin
      row = lps_row(i_pStateIdx);
      case (i_ivlCurrRange[7:6])
         2'd0:    lps = row[31:24];
         2'd1:    lps = row[23:16];
         2'd2:    lps = row[15:8];
         default: lps = row[7:0];
      endcase
      r_mps  = i_ivlCurrRange - {1'b0, lps};
      is_lps = (i_ivlOffset >= r_mps);

      range_pre   = r_mps;
      offset_pre  = i_ivlOffset;
      o_binVal    = i_valMps;
      o_valMps    = i_valMps;
      o_pStateIdx = (i_pStateIdx >= 6'd62) ? 6'd62 : i_pStateIdx + 6'd1;
      if (is_lps) begin
         range_pre   = {1'b0, lps};
         offset_pre  = i_ivlOffset - r_mps;
         o_binVal    = ~i_valMps;
         o_valMps    = (i_pStateIdx == 6'd0) ? ~i_valMps : i_valMps;
         o_pStateIdx = trans_lps(i_pStateIdx);
      end

      // Legal states never leave range below 6, so the final arm caps at 6 shifts
      // and the reserved state 63 still yields defined outputs.
      if (range_pre[8])      len = 3'd0;
      else if (range_pre[7]) len = 3'd1;
      else if (range_pre[6]) len = 3'd2;
      else if (range_pre[5]) len = 3'd3;
      else if (range_pre[4]) len = 3'd4;
      else if (range_pre[3]) len = 3'd5;
      else                   len = 3'd6;

      // Shifting offset and look-ahead bits as one word pulls the first len
      // bitstream bits into the offset LSBs.
      off_ext        = {offset_pre, i_rbsp_in} << len;
      o_ivlOffset    = off_ext[14:6];
      o_ivlCurrRange = range_pre << len;
      o_output_len   = len;
   end

endmodule

// File: tb/tb_cabac_decode_bin_core.sv
// tb/tb_cabac_decode_bin_core.sv - self-checking bench for cabac_decode_bin_core
module tb_cabac_decode_bin_core;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [8:0] i_ivlCurrRange = '0;
   logic [8:0] i_ivlOffset = '0;
   logic [5:0] i_pStateIdx = '0;
   logic       i_valMps = 1'b0;
   logic [5:0] i_rbsp_in = '0;
   logic [8:0] o_ivlCurrRange;
   logic [8:0] o_ivlOffset;
   logic [5:0] o_pStateIdx;
   logic       o_valMps;
   logic       o_binVal;
   logic [2:0] o_output_len;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cabac_decode_bin_core dut (
      .clk(clk), .rst(rst),
      .i_ivlCurrRange(i_ivlCurrRange), .i_ivlOffset(i_ivlOffset),
      .i_pStateIdx(i_pStateIdx), .i_valMps(i_valMps), .i_rbsp_in(i_rbsp_in),
      .o_ivlCurrRange(o_ivlCurrRange), .o_ivlOffset(o_ivlOffset),
      .o_pStateIdx(o_pStateIdx), .o_valMps(o_valMps), .o_binVal(o_binVal),
      .o_output_len(o_output_len)
   );

   int lps_tab [64][4] = '{
      '{128,176,208,240}, '{128,167,197,227}, '{128,158,187,216}, '{123,150,178,205},
      '{116,142,169,195}, '{111,135,160,185}, '{105,128,152,175}, '{100,122,144,166},
      '{95,116,137,158},  '{90,110,130,150},  '{85,104,123,142},  '{81,99,117,135},
      '{77,94,111,128},   '{73,89,105,122},   '{69,85,100,116},   '{66,80,95,110},
      '{62,76,90,104},    '{59,72,86,99},     '{56,69,81,94},     '{53,65,77,89},
      '{51,62,73,85},     '{48,59,69,80},     '{46,56,66,76},     '{43,53,63,72},
      '{41,50,59,69},     '{39,48,56,65},     '{37,45,54,62},     '{35,43,51,59},
      '{33,41,48,56},     '{32,39,46,53},     '{30,37,43,50},     '{29,35,41,48},
      '{27,33,39,45},     '{26,31,37,43},     '{24,30,35,41},     '{23,28,33,39},
      '{22,27,32,37},     '{21,26,30,35},     '{20,24,29,33},     '{19,23,27,31},
      '{18,22,26,30},     '{17,21,25,28},     '{16,20,23,27},     '{15,19,22,25},
      '{14,18,21,24},     '{14,17,20,23},     '{13,16,19,22},     '{12,15,18,21},
      '{12,14,17,20},     '{11,14,16,19},     '{11,13,15,18},     '{10,12,15,17},
      '{10,12,14,16},     '{9,11,13,15},      '{9,11,12,14},      '{8,10,12,14},
      '{8,9,11,13},       '{7,9,11,12},       '{7,9,10,12},       '{7,8,10,11},
      '{6,8,9,11},        '{6,7,9,10},        '{6,7,8,9},         '{2,2,2,2}
   };

   int trans_lps [64] = '{
      0,0,1,2,2,4,4,5,6,7,8,9,9,11,11,12,13,13,15,15,16,16,18,18,19,19,21,21,22,22,23,24,
      24,25,26,26,27,27,28,29,29,30,30,30,31,32,32,33,33,33,34,34,35,35,35,36,36,36,37,37,37,38,38,63
   };

   // Reference: decide the bin arithmetically, then renormalise one bit at a time
   // reading the look-ahead bits in stream order.
   task automatic ref_model(input int rng, input int off, input int pst, input int mps,
                            input int rbsp, output int e_bin, output int e_rng,
                            output int e_off, output int e_pst, output int e_mps,
                            output int e_len);
      int lps;
      int rmps;
      lps  = lps_tab[pst][(rng / 64) % 4];
      rmps = rng - lps;
      if (off < rmps) begin
         e_bin = mps;
         e_rng = rmps;
         e_off = off;
         e_pst = (pst < 62) ? pst + 1 : 62;
         e_mps = mps;
      end else begin
         e_bin = 1 - mps;
         e_rng = lps;
         e_off = off - rmps;
         e_pst = trans_lps[pst];
         e_mps = (pst == 0) ? 1 - mps : mps;
      end
      e_len = 0;
      while (e_rng < 256 && e_len < 6) begin
         e_rng = e_rng * 2;
         e_off = (e_off * 2 + ((rbsp >> (5 - e_len)) % 2)) % 512;
         e_len = e_len + 1;
      end
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic apply(input int rng, input int off, input int pst, input int mps,
                        input int rbsp);
      @(negedge clk);
      i_ivlCurrRange = 9'(rng);
      i_ivlOffset    = 9'(off);
      i_pStateIdx    = 6'(pst);
      i_valMps       = 1'(mps);
      i_rbsp_in      = 6'(rbsp);
      #1;
   endtask

   task automatic chk_all(input string tag, input int bin, input int rng, input int off,
                          input int pst, input int mps, input int len);
      chk({tag, "_bin"},   16'(o_binVal),       16'(bin));
      chk({tag, "_range"}, 16'(o_ivlCurrRange), 16'(rng));
      chk({tag, "_off"},   16'(o_ivlOffset),    16'(off));
      chk({tag, "_pst"},   16'(o_pStateIdx),    16'(pst));
      chk({tag, "_mps"},   16'(o_valMps),       16'(mps));
      chk({tag, "_len"},   16'(o_output_len),   16'(len));
   endtask

   initial begin
      int e_bin, e_rng, e_off, e_pst, e_mps, e_len;
      int rng, off, mps, rbsp;

      repeat (2) @(posedge clk);
      rst = 1'b1;

      // MPS at the widest range, state 0 -> 1.
      apply(510, 0, 0, 0, 0);
      chk_all("t1", 0, 270, 0, 1, 0, 0);
      // LPS at state 0 flips the MPS; one renorm bit taken from rbsp.
      apply(510, 300, 0, 0, 6'b101010);
      chk_all("t2", 1, 480, 61, 0, 1, 1);
      // LPS from state 62 at the smallest range: maximum six-bit renorm.
      apply(256, 255, 62, 1, 6'b111111);
      chk_all("t3", 0, 384, 383, 38, 1, 6);
      // MPS saturation at 62, and 61 -> 62.
      apply(510, 0, 62, 1, 0);
      chk_all("t4a", 1, 501, 0, 62, 1, 0);
      apply(510, 0, 61, 1, 0);
      chk_all("t4b", 1, 500, 0, 62, 1, 0);
      // MPS path that still needs one renorm shift.
      apply(256, 10, 0, 1, 6'b100000);
      chk_all("t5", 1, 256, 21, 1, 1, 1);
      // LPS with MPS=1 at non-zero state keeps MPS.
      apply(300, 299, 10, 1, 6'b011011);
      ref_model(300, 299, 10, 1, 6'b011011, e_bin, e_rng, e_off, e_pst, e_mps, e_len);
      chk_all("t6", e_bin, e_rng, e_off, e_pst, e_mps, e_len);

      // Random sweep over every legal state, reset toggled at random throughout.
      for (int pst = 0; pst <= 62; pst++) begin
         for (int k = 0; k < 8; k++) begin
            rng  = int'($urandom_range(510, 256));
            off  = (k % 2 == 0) ? int'($urandom_range(rng - 1, 0))
                                : int'($urandom_range(rng - 1, rng - 60));
            mps  = int'($urandom_range(1, 0));
            rbsp = int'($urandom_range(63, 0));
            rst  = 1'($urandom_range(1, 0));
            apply(rng, off, pst, mps, rbsp);
            ref_model(rng, off, pst, mps, rbsp, e_bin, e_rng, e_off, e_pst, e_mps, e_len);
            chk_all("sweep", e_bin, e_rng, e_off, e_pst, e_mps, e_len);
            chk("sweep_rng_lo", 16'(o_ivlCurrRange >= 9'd256), 16'(1));
            chk("sweep_off_lt", 16'(o_ivlOffset < o_ivlCurrRange), 16'(1));
         end
      end
      rst = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
